// File: rtl/noc_pkg.sv
// Shared NoC router definitions: flit width, output-port indices and the
// input-buffer handshake states.
package noc_pkg;

  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int NUM_PORTS          = 5;

  localparam int PORT_N = 0;
  localparam int PORT_E = 1;
  localparam int PORT_W = 2;
  localparam int PORT_S = 3;
  localparam int PORT_L = 4;

  typedef logic [DEFAULT_DATA_WIDTH-1:0] flit_t;

  typedef enum logic {
    HS_IDLE = 1'b0,
    HS_ACK  = 1'b1
  } hs_state_t;

endpackage

// File: rtl/fifo_regfile.sv
// Flit storage for one input buffer: synchronous write, asynchronous read,
// whole array cleared on reset.
module fifo_regfile #(
  parameter  int DATA_WIDTH = noc_pkg::DEFAULT_DATA_WIDTH,
  parameter  int DEPTH      = 4,
  localparam int PTR_W      = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [PTR_W-1:0]      waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [PTR_W-1:0]      raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem_r [DEPTH];

  // Storage array: clear on reset, otherwise write the addressed entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  assign rdata = mem_r[raddr];

endmodule

// File: rtl/input_fifo_cts.sv
// Router input-port buffer: accepts one flit per RTS/CTS handshake into a
// circular FIFO and presents the head flit to the crossbar.
module input_fifo_cts
  import noc_pkg::*;
#(
  parameter  int DATA_WIDTH = noc_pkg::DEFAULT_DATA_WIDTH,
  parameter  int DEPTH      = 4,
  localparam int PTR_W      = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] RX,
  input  logic                  DRTS,
  output logic                  CTS,
  input  logic [NUM_PORTS-1:0]  read_en,
  output logic [DATA_WIDTH-1:0] Data_out,
  output logic                  empty,
  output logic                  full,
  output logic [PTR_W:0]        count
);

  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W + 1)'(1);
  localparam logic [PTR_W:0]   CNT_FULL = (PTR_W + 1)'(DEPTH);

  hs_state_t        state_r;
  hs_state_t        state_nxt_s;
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [PTR_W:0]   count_r;
  logic             wr_en_s;
  logic             rd_en_s;

  // Flags come from occupancy so a full and an empty FIFO never alias.
  assign empty = (count_r == '0);
  assign full  = (count_r == CNT_FULL);
  assign count = count_r;
  assign CTS   = (state_r == HS_ACK);

  // ~CTS keeps a DRTS still held during the acknowledge cycle from writing twice.
  assign wr_en_s = DRTS & ~CTS & ~full;
  assign rd_en_s = (|read_en) & ~empty;

  // Handshake state register; CTS is decoded straight from it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= HS_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Handshake next state: acknowledge each accepted flit for one cycle.
  always_comb begin
    state_nxt_s = HS_IDLE;
    case (state_r)
      HS_IDLE: begin
        if (wr_en_s) begin
          state_nxt_s = HS_ACK;
        end else begin
          state_nxt_s = HS_IDLE;
        end
      end
      HS_ACK:  state_nxt_s = HS_IDLE;
      default: state_nxt_s = HS_IDLE;
    endcase
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
    end else begin
      if (wr_en_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (rd_en_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
    end
  end

  // Occupancy counter; a simultaneous push and pop leaves it unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r <= '0;
    end else begin
      case ({wr_en_s, rd_en_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  fifo_regfile #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_regfile (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_en_s),
    .waddr (wr_ptr_r),
    .wdata (RX),
    .raddr (rd_ptr_r),
    .rdata (Data_out)
  );

endmodule

// File: tb/tb_input_fifo_cts.sv
// Self-checking bench for input_fifo_cts: directed scenarios plus random
// traffic, all compared against a queue-based reference model.
module tb_input_fifo_cts;

  localparam int DW    = 32;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] RX;
  logic          DRTS;
  logic          CTS;
  logic [4:0]    read_en;
  logic [DW-1:0] Data_out;
  logic          empty;
  logic          full;
  logic [2:0]    count;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: flit queue, CTS bit, and whether storage is still all-zero.
  logic [DW-1:0] q_m [$];
  bit            cts_m     = 1'b0;
  bit            mem_clean = 1'b1;

  input_fifo_cts #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .RX       (RX),
    .DRTS     (DRTS),
    .CTS      (CTS),
    .read_en  (read_en),
    .Data_out (Data_out),
    .empty    (empty),
    .full     (full),
    .count    (count)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got running, want finished");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_model();
    check_eq("cts",   64'(CTS),   64'(cts_m));
    check_eq("count", 64'(count), 64'(q_m.size()));
    check_eq("empty", 64'(empty), 64'(q_m.size() == 0));
    check_eq("full",  64'(full),  64'(q_m.size() == DEPTH));
    if (q_m.size() != 0) begin
      check_eq("data_out", 64'(Data_out), 64'(q_m[0]));
    end else if (mem_clean) begin
      check_eq("data_out_clr", 64'(Data_out), 64'd0);
    end
  endtask

  // One clock: drive at negedge, advance model at posedge, compare after it.
  task automatic cycle(input bit drts, input logic [DW-1:0] d, input logic [4:0] rd, input bit r);
    bit wr;
    bit pop;
    @(negedge clk);
    DRTS = drts; RX = d; read_en = rd; rst = r;
    @(posedge clk);
    if (r) begin
      q_m.delete();
      cts_m     = 1'b0;
      mem_clean = 1'b1;
    end else begin
      wr  = drts && !cts_m && (q_m.size() < DEPTH);
      pop = (rd != 5'd0) && (q_m.size() != 0);
      if (pop) void'(q_m.pop_front());
      if (wr) begin
        q_m.push_back(d);
        mem_clean = 1'b0;
      end
      cts_m = wr;
    end
    #1;
    check_model();
  endtask

  // Hold DRTS/RX until CTS is seen, then drop DRTS for one cycle.
  task automatic handshake(input logic [DW-1:0] d);
    bit ok = 1'b0;
    for (int n = 0; n < 16 && !ok; n++) begin
      cycle(1'b1, d, 5'd0, 1'b0);
      if (CTS === 1'b1) ok = 1'b1;
    end
    check_eq("hs_cts_seen", 64'(ok), 64'd1);
    cycle(1'b0, d, 5'd0, 1'b0);
  endtask

  task automatic pop_expect(input logic [DW-1:0] exp);
    check_eq("pop_order", 64'(Data_out), 64'(exp));
    cycle(1'b0, '0, 5'b10000, 1'b0);
  endtask

  initial begin
    bit            drts_a = 1'b0;
    logic [DW-1:0] d_a    = '0;
    logic [4:0]    rd_a;
    bit            rst_a;

    DRTS = 1'b0; RX = '0; read_en = 5'd0; rst = 1'b1;

    // Reset then idle
    cycle(1'b0, '0, 5'd0, 1'b1);
    cycle(1'b0, '0, 5'd0, 1'b1);
    cycle(1'b0, '0, 5'd0, 1'b0);
    check_eq("rst_cts",   64'(CTS),      64'd0);
    check_eq("rst_empty", 64'(empty),    64'd1);
    check_eq("rst_full",  64'(full),     64'd0);
    check_eq("rst_count", 64'(count),    64'd0);
    check_eq("rst_data",  64'(Data_out), 64'd0);

    // Single handshake: CTS pulses exactly once
    cycle(1'b1, 32'hA5A5_0001, 5'd0, 1'b0);
    check_eq("hs1_cts_hi", 64'(CTS),      64'd1);
    check_eq("hs1_count",  64'(count),    64'd1);
    check_eq("hs1_data",   64'(Data_out), 64'hA5A5_0001);
    cycle(1'b0, 32'hA5A5_0001, 5'd0, 1'b0);
    check_eq("hs1_cts_lo", 64'(CTS),      64'd0);
    cycle(1'b0, '0, 5'b00001, 1'b0);
    check_eq("hs1_empty",  64'(empty),    64'd1);

    // Fill and backpressure
    for (int i = 1; i <= 4; i++) handshake(DW'(i));
    check_eq("fill_full",  64'(full),  64'd1);
    check_eq("fill_count", 64'(count), 64'd4);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 32'd5, 5'd0, 1'b0);
      check_eq("bp_cts_lo", 64'(CTS), 64'd0);
    end
    check_eq("bp_head", 64'(Data_out), 64'd1);
    cycle(1'b1, 32'd5, 5'b10000, 1'b0);
    check_eq("bp_pop_cts", 64'(CTS),   64'd0);
    check_eq("bp_pop_cnt", 64'(count), 64'd3);
    cycle(1'b1, 32'd5, 5'd0, 1'b0);
    check_eq("bp_accept",  64'(CTS),   64'd1);
    cycle(1'b0, 32'd5, 5'd0, 1'b0);
    for (int i = 2; i <= 5; i++) pop_expect(DW'(i));
    check_eq("drain_empty", 64'(empty), 64'd1);

    // Simultaneous read/write at count=2
    handshake(32'h0000_0011);
    handshake(32'h0000_0022);
    cycle(1'b1, 32'hDEAD_BEEF, 5'b00100, 1'b0);
    check_eq("rw_count", 64'(count),    64'd2);
    check_eq("rw_head",  64'(Data_out), 64'h0000_0022);
    check_eq("rw_cts",   64'(CTS),      64'd1);
    cycle(1'b0, 32'hDEAD_BEEF, 5'd0, 1'b0);
    check_eq("rw_cts_lo", 64'(CTS),     64'd0);
    pop_expect(32'h0000_0022);
    pop_expect(32'hDEAD_BEEF);

    // Wrap-around with write/read pairs
    for (int i = 0; i < 10; i++) begin
      handshake(DW'(i));
      check_eq("wrap_count", 64'(count), 64'd1);
      pop_expect(DW'(i));
    end

    // Reset mid-operation with DRTS pending
    for (int i = 0; i < 3; i++) handshake(DW'(32'h100 + i));
    check_eq("mid_count", 64'(count), 64'd3);
    cycle(1'b1, 32'h77, 5'd0, 1'b1);
    check_eq("mid_rst_cts",   64'(CTS),      64'd0);
    check_eq("mid_rst_count", 64'(count),    64'd0);
    check_eq("mid_rst_empty", 64'(empty),    64'd1);
    check_eq("mid_rst_data",  64'(Data_out), 64'd0);
    cycle(1'b0, '0, 5'd0, 1'b0);
    handshake(32'h88);
    check_eq("post_rst_data", 64'(Data_out), 64'h88);
    pop_expect(32'h88);

    // Random traffic against the model
    for (int n = 0; n < 600; n++) begin
      rst_a = ($urandom_range(0, 199) == 0);
      if (!drts_a && $urandom_range(0, 2) == 0) begin
        drts_a = 1'b1;
        d_a    = $urandom;
      end
      case ($urandom_range(0, 5))
        0:       rd_a = 5'b00001 << $urandom_range(0, 4);
        1:       rd_a = 5'b00001 << $urandom_range(0, 4);
        2:       rd_a = 5'b11000;
        default: rd_a = 5'd0;
      endcase
      cycle(drts_a, d_a, rd_a, rst_a);
      if (rst_a || cts_m) drts_a = 1'b0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
